// File: rtl/board_uart_serializer.sv
// Serialises a captured board frame, one byte per UART handshake, top byte first.
// Each byte waits for the transmitter to go busy (or for a timeout) and then idle again.
module board_uart_serializer #(
  parameter int FRAME_BYTES = 80,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FRAME_BYTES*8-1:0] i_frame,
  input  logic                     i_frame_stb,
  input  logic                     i_tx_busy,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_stb,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_drop
);

  localparam int FW    = FRAME_BYTES * 8;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, LOAD, STROBE, WAIT_ACK, WAIT_IDLE, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (i_frame_stb) begin
          frame_d = i_frame;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!i_tx_busy) begin
          data_d  = frame_q[FW-1 -: 8];
          state_d = STROBE;
        end
      end
      STROBE: begin
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A transmitter that never raises busy still lets the frame advance.
        if (i_tx_busy) begin
          state_d = WAIT_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q + 1'b1 == TMO_MAX) state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!i_tx_busy) begin
          frame_d = {frame_q[FW-9:0], 8'h00};
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST_BYTE) ? DONE : LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_tx_data = data_q;
    o_tx_stb  = (state_q == STROBE);
    o_busy    = (state_q != IDLE);
    o_done    = (state_q == DONE);
    // Reset takes priority over a coincident request, so no drop is flagged then.
    o_drop    = i_frame_stb && !rst && (state_q != IDLE);
  end

endmodule

// File: tb/tb_board_uart_serializer.sv
// Directed bench for board_uart_serializer with a small UART busy model.
// Each scenario task drives stimulus and checks its own expectations inline.
module tb_board_uart_serializer;
  localparam int FB = 80;
  localparam int FW = FB * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] i_frame;
  logic          i_frame_stb;
  logic          i_tx_busy;
  logic [7:0]    o_tx_data;
  logic          o_tx_stb, o_busy, o_done, o_drop;

  always #5 clk = ~clk;

  board_uart_serializer #(.FRAME_BYTES(FB), .ACK_TIMEOUT(15), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .i_frame(i_frame), .i_frame_stb(i_frame_stb),
    .i_tx_busy(i_tx_busy), .o_tx_data(o_tx_data), .o_tx_stb(o_tx_stb),
    .o_busy(o_busy), .o_done(o_done), .o_drop(o_drop)
  );

  int checks = 0;
  int errors = 0;

  // UART model: busy for busy_len cycles after each strobe (0 = never busy).
  int   busy_len = 0;
  int   busy_cnt = 0;
  int   cyc = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_tx_stb && busy_len > 0) busy_cnt <= busy_len;
    else if (busy_cnt > 0)        busy_cnt <= busy_cnt - 1;
  end
  assign i_tx_busy = force_busy || (busy_cnt != 0);

  logic [7:0] rec[1024];
  int         rec_cyc[1024];
  int stb_cnt = 0, done_cnt = 0, drop_cnt = 0, viol_cnt = 0;
  always @(negedge clk) begin
    if (o_tx_stb) begin
      if (stb_cnt < 1024) begin
        rec[stb_cnt]     <= o_tx_data;
        rec_cyc[stb_cnt] <= cyc;
      end
      stb_cnt <= stb_cnt + 1;
      if (i_tx_busy) viol_cnt <= viol_cnt + 1;
    end
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_drop) drop_cnt <= drop_cnt + 1;
  end

  logic [7:0]    init_b[FB];
  logic [7:0]    cur_b[FB];
  logic [7:0]    alt_b[FB];
  logic [FW-1:0] f_init, f_cur, f_alt;

  function automatic logic [FW-1:0] pack(input logic [7:0] b[FB]);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < FB; k++) f[(FB-1-k)*8 +: 8] = b[k];
    return f;
  endfunction

  task automatic build_frames();
    string ranks[8];
    ranks = '{"rnbqkbnr", "pppppppp", "........", "........",
              "........", "........", "PPPPPPPP", "RNBQKBNR"};
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) init_b[r*10+c] = ranks[r].getc(c);
      init_b[r*10+8] = 8'h0A;
      init_b[r*10+9] = 8'h0D;
    end
    for (int k = 0; k < FB; k++) begin
      cur_b[k] = init_b[k];
      alt_b[k] = 8'h23;
    end
    cur_b[0] = 8'h40;
    f_init = pack(init_b);
    f_cur  = pack(cur_b);
    f_alt  = pack(alt_b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [FW-1:0] f);
    tick();
    i_frame     = f;
    i_frame_stb = 1'b1;
    tick();
    i_frame_stb = 1'b0;
    i_frame     = ~f;
  endtask

  task automatic wait_not_busy(input int budget, input string tag);
    int n = 0;
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (o_busy) begin
      errors++;
      $display("FAIL %s_timeout: o_busy still %0b after %0d cycles, required 0", tag, o_busy, budget);
    end
  endtask

  task automatic wait_stb(input int target, input int budget, input string tag);
    int n = 0;
    while (stb_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (stb_cnt < target) begin
      errors++;
      $display("FAIL %s_stb_wait: strobes %0d, required %0d", tag, stb_cnt, target);
    end
  endtask

  task automatic check_bytes(input int base, input string tag);
    for (int i = 0; i < FB; i++) begin
      checks++;
      if (rec[base+i] !== init_b[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h, required %h", tag, i, rec[base+i], init_b[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_frame_stb = 1'b0; i_frame = '0; force_busy = 1'b0;
    repeat (3) tick();
    checks += 5;
    if (o_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", o_tx_data); end
    if (o_tx_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b, required 0", o_tx_stb); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", o_done); end
    if (o_drop !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b, required 0", o_drop); end
    // Request coincident with reset must not be captured.
    i_frame = f_init; i_frame_stb = 1'b1;
    tick();
    i_frame_stb = 1'b0; rst = 1'b0;
    tick();
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_stb_capture: o_busy %b, required 0", o_busy); end
  endtask

  task automatic test_full_frame();
    int base = stb_cnt;
    int dbase = done_cnt;
    busy_len = 10;
    tick();
    i_frame = f_init; i_frame_stb = 1'b1;
    tick();
    i_frame_stb = 1'b0; i_frame = ~f_init;
    checks += 2;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL full_busy_c1: got %b, required 1", o_busy); end
    if (o_tx_stb !== 1'b0) begin errors++; $display("FAIL full_stb_c1: got %b, required 0", o_tx_stb); end
    tick();
    checks += 2;
    if (o_tx_stb !== 1'b1) begin errors++; $display("FAIL full_stb_c2: got %b, required 1", o_tx_stb); end
    if (o_tx_data !== 8'h72) begin errors++; $display("FAIL full_first: got %h, required 72", o_tx_data); end
    wait_not_busy(3000, "full");
    checks += 4;
    if (stb_cnt - base != FB) begin errors++; $display("FAIL full_count: got %0d, required %0d", stb_cnt - base, FB); end
    if (rec[base+FB-1] !== 8'h0D) begin errors++; $display("FAIL full_last: got %h, required 0d", rec[base+FB-1]); end
    if (done_cnt - dbase != 1) begin errors++; $display("FAIL full_done: got %0d, required 1", done_cnt - dbase); end
    if (viol_cnt != 0) begin errors++; $display("FAIL full_stb_while_busy: got %0d, required 0", viol_cnt); end
    check_bytes(base, "full");
  endtask

  task automatic test_busy_hold();
    int base = stb_cnt;
    int dbase = done_cnt;
    busy_len = 3;
    force_busy = 1'b1;
    send_frame(f_init);
    repeat (48) tick();
    checks += 2;
    if (stb_cnt != base) begin errors++; $display("FAIL hold_no_stb: got %0d strobes, required 0", stb_cnt - base); end
    if (o_busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b, required 1", o_busy); end
    tick();
    force_busy = 1'b0;
    // Strobe lands two cycles after the last cycle busy was high.
    @(negedge clk);
    checks++;
    if (o_tx_stb !== 1'b0) begin errors++; $display("FAIL hold_stb_early: got %b, required 0", o_tx_stb); end
    @(negedge clk);
    checks++;
    if (o_tx_stb !== 1'b1) begin errors++; $display("FAIL hold_stb_after_fall: got %b, required 1", o_tx_stb); end
    #1;
    wait_not_busy(3000, "hold");
    checks += 3;
    if (stb_cnt - base != FB) begin errors++; $display("FAIL hold_count: got %0d, required %0d", stb_cnt - base, FB); end
    if (done_cnt - dbase != 1) begin errors++; $display("FAIL hold_done: got %0d, required 1", done_cnt - dbase); end
    if (viol_cnt != 0) begin errors++; $display("FAIL hold_stb_while_busy: got %0d, required 0", viol_cnt); end
  endtask

  task automatic test_timeout();
    int base = stb_cnt;
    int dbase = done_cnt;
    busy_len = 0;
    send_frame(f_init);
    wait_not_busy(4000, "tmo");
    checks += 4;
    if (stb_cnt - base != FB) begin errors++; $display("FAIL tmo_count: got %0d, required %0d", stb_cnt - base, FB); end
    // LOAD + STROBE + 15 WAIT_ACK + WAIT_IDLE per byte.
    if (rec_cyc[base+1] - rec_cyc[base] != 18) begin
      errors++; $display("FAIL tmo_spacing: got %0d, required 18", rec_cyc[base+1] - rec_cyc[base]);
    end
    if (done_cnt - dbase != 1) begin errors++; $display("FAIL tmo_done: got %0d, required 1", done_cnt - dbase); end
    if (rec[base+FB-1] !== 8'h0D) begin errors++; $display("FAIL tmo_last: got %h, required 0d", rec[base+FB-1]); end
  endtask

  task automatic test_drop();
    int base = stb_cnt;
    int dbase = done_cnt;
    int pbase = drop_cnt;
    busy_len = 2;
    send_frame(f_init);
    wait_stb(base + 30, 1000, "drop");
    tick();
    i_frame = f_alt; i_frame_stb = 1'b1;
    @(negedge clk);
    checks++;
    if (o_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b, required 1", o_drop); end
    tick();
    i_frame_stb = 1'b0;
    wait_not_busy(3000, "drop");
    checks += 3;
    if (drop_cnt - pbase != 1) begin errors++; $display("FAIL drop_count: got %0d, required 1", drop_cnt - pbase); end
    if (stb_cnt - base != FB) begin errors++; $display("FAIL drop_bytes: got %0d, required %0d", stb_cnt - base, FB); end
    if (done_cnt - dbase != 1) begin errors++; $display("FAIL drop_done: got %0d, required 1", done_cnt - dbase); end
    check_bytes(base, "drop");
  endtask

  task automatic test_reset_mid();
    int base = stb_cnt;
    int dbase = done_cnt;
    int n;
    busy_len = 1;
    send_frame(f_init);
    wait_stb(base + 40, 1000, "rstmid");
    tick();
    rst = 1'b1; i_frame_stb = 1'b1;
    @(negedge clk);
    checks++;
    if (o_drop !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got %b, required 0", o_drop); end
    tick();
    rst = 1'b0; i_frame_stb = 1'b0;
    @(negedge clk);
    checks += 5;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", o_busy); end
    if (o_tx_stb !== 1'b0) begin errors++; $display("FAIL rstmid_stb: got %b, required 0", o_tx_stb); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b, required 0", o_done); end
    if (o_tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h, required 00", o_tx_data); end
    if (o_drop !== 1'b0) begin errors++; $display("FAIL rstmid_drop2: got %b, required 0", o_drop); end
    #1;
    n = stb_cnt;
    repeat (30) tick();
    checks += 2;
    if (stb_cnt != n) begin errors++; $display("FAIL rstmid_stall: got %0d strobes, required 0", stb_cnt - n); end
    if (done_cnt != dbase) begin errors++; $display("FAIL rstmid_no_done: got %0d, required 0", done_cnt - dbase); end
    base = stb_cnt;
    dbase = done_cnt;
    send_frame(f_init);
    wait_not_busy(1000, "rstmid");
    checks += 3;
    if (rec[base] !== 8'h72) begin errors++; $display("FAIL rstmid_restart: got %h, required 72", rec[base]); end
    if (stb_cnt - base != FB) begin errors++; $display("FAIL rstmid_count: got %0d, required %0d", stb_cnt - base, FB); end
    if (done_cnt - dbase != 1) begin errors++; $display("FAIL rstmid_done: got %0d, required 1", done_cnt - dbase); end
  endtask

  task automatic test_back_to_back();
    int base = stb_cnt;
    int dbase = done_cnt;
    int pbase = drop_cnt;
    int n = 0;
    busy_len = 1;
    send_frame(f_cur);
    while (!o_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_done !== 1'b1) begin errors++; $display("FAIL b2b_done_wait: o_done %b, required 1", o_done); end
    tick();
    i_frame = f_init; i_frame_stb = 1'b1;
    @(negedge clk);
    checks += 2;
    if (o_drop !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b, required 0", o_drop); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b, required 0", o_busy); end
    tick();
    i_frame_stb = 1'b0;
    wait_not_busy(1000, "b2b");
    checks += 6;
    if (stb_cnt - base != 2 * FB) begin errors++; $display("FAIL b2b_count: got %0d, required %0d", stb_cnt - base, 2 * FB); end
    if (rec[base] !== 8'h40) begin errors++; $display("FAIL b2b_cursor: got %h, required 40", rec[base]); end
    if (rec[base+1] !== 8'h6E) begin errors++; $display("FAIL b2b_byte1: got %h, required 6e", rec[base+1]); end
    if (rec[base+FB] !== 8'h72) begin errors++; $display("FAIL b2b_second: got %h, required 72", rec[base+FB]); end
    if (drop_cnt != pbase) begin errors++; $display("FAIL b2b_drops: got %0d, required 0", drop_cnt - pbase); end
    if (done_cnt - dbase != 2) begin errors++; $display("FAIL b2b_dones: got %0d, required 2", done_cnt - dbase); end
  endtask

  initial begin
    build_frames();
    test_reset();
    test_full_frame();
    test_busy_hold();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
